// File: rtl/rounding_pkg.sv
// rounding_pkg: rounding mode encodings shared by the rounding pipeline
package rounding_pkg;
    typedef enum logic [1:0] {
        RND_RNE = 2'd0,
        RND_RTZ = 2'd1,
        RND_RUP = 2'd2,
        RND_RDN = 2'd3
    } rnd_mode_e;
endpackage

// File: rtl/round_incr_decide.sv
// round_incr_decide: increment and inexact decision from the discarded mantissa bits
module round_incr_decide
    import rounding_pkg::*;
#(
    parameter int IN_W  = 27,
    parameter int OUT_W = 24
) (
    input  logic [IN_W-OUT_W:0] low,
    input  logic                sign,
    input  logic [1:0]          mode,
    output logic                incr,
    output logic                inexact
);
    logic l, r, s;
    always_comb begin
        l = low[IN_W-OUT_W];
        r = low[IN_W-OUT_W-1];
        s = |low[IN_W-OUT_W-2:0];
        inexact = r | s;
        incr = mode == RND_RNE ? r & (l | s) :
               mode == RND_RUP ? inexact & ~sign :
               mode == RND_RDN ? inexact & sign : 1'b0;
    end
endmodule

// File: rtl/rounding_pipe.sv
// rounding_pipe: two-stage valid/ready pipeline rounding an MSB-aligned mantissa to OUT_W bits
module rounding_pipe
    import rounding_pkg::*;
#(
    parameter int IN_W  = 27,
    parameter int OUT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [1:0]       in_mode,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_mant,
    output logic             out_sign,
    output logic             out_overfl,
    output logic             out_inexact
);
    localparam int LW = IN_W - OUT_W;
    logic             s1_valid, s1_sign, s1_incr, s1_inexact;
    logic [OUT_W-1:0] s1_t;
    logic             d_incr, d_inexact, s2_adv;
    logic [OUT_W:0]   sum;
    round_incr_decide #(.IN_W(IN_W), .OUT_W(OUT_W)) u_decide (
        .low     (in_data[LW:0]),
        .sign    (in_sign),
        .mode    (in_mode),
        .incr    (d_incr),
        .inexact (d_inexact)
    );
    // stage 1 drains whenever stage 2 can take its beat, so in_ready never depends on in_valid
    assign s2_adv   = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_adv;
    assign sum      = {1'b0, s1_t} + {{OUT_W{1'b0}}, s1_incr};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_t       <= '0;
            s1_sign    <= 1'b0;
            s1_incr    <= 1'b0;
            s1_inexact <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_valid & in_ready) begin
                s1_t       <= in_data[IN_W-1:LW];
                s1_sign    <= in_sign;
                s1_incr    <= d_incr;
                s1_inexact <= d_inexact;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_mant    <= '0;
            out_sign    <= 1'b0;
            out_overfl  <= 1'b0;
            out_inexact <= 1'b0;
        end else begin
            if (s2_adv) out_valid <= s1_valid;
            if (s1_valid & s2_adv) begin
                out_mant    <= sum[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : sum[OUT_W-1:0];
                out_overfl  <= sum[OUT_W];
                out_sign    <= s1_sign;
                out_inexact <= s1_inexact;
            end
        end
    end
endmodule

// File: doc/rounding_pipe.md
ROUNDING_PIPE -- requirements
Module: rounding_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 27, width of the unrounded input mantissa; legal range IN_W >= OUT_W + 2.
REQ-002 SHALL have parameter OUT_W, default 24, width of the rounded output mantissa.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, input beat present.
REQ-006 SHALL have port in_ready, output, 1, block accepts the input beat this cycle.
REQ-007 SHALL have port in_sign, input, 1, sign of the value being rounded.
REQ-008 SHALL have port in_mode, input, 2, rounding mode: 0 RNE, 1 RTZ, 2 toward +inf, 3 toward -inf.
REQ-009 SHALL have port in_data, input, IN_W, unrounded mantissa, MSB aligned.
REQ-010 SHALL have port out_valid, output, 1, result beat present.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the result beat.
REQ-012 SHALL have port out_mant, output, OUT_W, rounded mantissa.
REQ-013 SHALL have port out_sign, output, 1, in_sign carried with the beat.
REQ-014 SHALL have port out_overfl, output, 1, rounding carried out of OUT_W bits.
REQ-015 SHALL have port out_inexact, output, 1, discarded bits were non-zero.

Function
REQ-016 SHALL transfer an input beat when in_valid & in_ready, and an output beat when out_valid & out_ready.
REQ-017 SHALL define T = in_data[IN_W-1:IN_W-OUT_W], L = in_data[IN_W-OUT_W], R = in_data[IN_W-OUT_W-1], S = OR of in_data[IN_W-OUT_W-2:0].
REQ-018 SHALL set inexact = R | S.
REQ-019 SHALL set the increment to: mode 0: R & (L | S); mode 1: 0; mode 2: inexact & ~sign; mode 3: inexact & sign.
REQ-020 SHALL, when T is all ones and the increment is 1, output out_mant = 1 followed by OUT_W-1 zeros and out_overfl = 1; otherwise out_mant = T + increment and out_overfl = 0.
REQ-021 SHALL implement two register stages: stage 1 registers T, sign, increment and inexact; stage 2 registers out_mant, out_overfl, out_inexact and out_sign.
REQ-022 SHALL present a beat on out_valid exactly 2 cycles after acceptance when out_ready stays high, and sustain 1 beat per cycle.
REQ-023 SHALL advance each stage when its output register is empty or is being drained in the same cycle; in_ready = ~s1_valid | s1_advance, with no combinational path from in_valid to in_ready.
REQ-024 SHALL hold out_mant, out_sign, out_overfl and out_inexact stable while out_valid & ~out_ready.
REQ-025 SHALL hold at most 2 beats in flight; with out_ready low and both stages full, in_ready SHALL be 0.
REQ-026 SHALL preserve beat order; accept and drain in the same cycle on a full pipe SHALL lose and duplicate nothing.
REQ-027 SHALL sample in_mode per beat, so mixed modes on back-to-back beats are legal.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear both stage valid flags, so that out_valid = 0 and in_ready = 1 after release.
REQ-029 SHALL reset out_mant, out_sign, out_overfl and out_inexact to 0.
REQ-030 SHALL discard any beats in flight when reset is asserted mid-operation; no stale beat SHALL appear after release.

Structure
REQ-031 SHALL place the mode encodings RND_RNE=0, RND_RTZ=1, RND_RUP=2 and RND_RDN=3 in a shared package rounding_pkg.
REQ-032 SHALL put the increment/inexact decision (REQ-017 to REQ-019) in one combinational sub-module, round_incr_decide, which the stage-1 logic uses.

Verification (IN_W=27, OUT_W=24, out_ready=1 unless stated)
REQ-033 SHALL cover RNE tie-to-even: in_data 27'h0000004 -> out_mant 0, inexact 1; in_data 27'h000000C -> out_mant 2, inexact 1; each 2 cycles after acceptance.
REQ-034 SHALL cover overflow: in_data 27'h7FFFFFF, mode 0 -> out_mant 24'h800000, overfl 1, inexact 1.
REQ-035 SHALL cover directed modes: in_data 27'h0000001, mode 2, sign 0 -> out_mant 1; sign 1 -> 0; mode 3, sign 1 -> 1; in_data 27'h0000008, mode 1 -> out_mant 1, inexact 0.
REQ-036 SHALL cover backpressure: 3 beats back-to-back with out_ready low for 4 cycles -> in_ready 0 after 2 accepts, outputs stable; on out_ready high -> all 3 beats delivered in order, 1 per cycle.
REQ-037 SHALL cover reset mid-flight: assert rst_n low with 2 beats in flight -> out_valid 0 immediately; after release, in_ready 1 and no beat is output until new input.
